// File: rtl/down_frame_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : down_frame_sched_pkg
// Description : Downlink gear codes, gear-to-frame-length decode, scheduler
//               state encoding.
// Revision    : 1.0
// ============================================================================
package down_frame_sched_pkg;

    localparam logic [7:0] c_gear_52 = 8'h52;
    localparam logic [7:0] c_gear_51 = 8'h51;
    localparam logic [7:0] c_gear_4f = 8'h4F;
    localparam logic [7:0] c_gear_4e = 8'h4E;
    localparam logic [7:0] c_gear_4d = 8'h4D;
    localparam logic [7:0] c_gear_4c = 8'h4C;
    localparam logic [7:0] c_gear_4b = 8'h4B;
    localparam logic [7:0] c_gear_4a = 8'h4A;
    localparam logic [7:0] c_gear_49 = 8'h49;
    localparam logic [7:0] c_gear_48 = 8'h48;
    localparam logic [7:0] c_gear_47 = 8'h47;
    localparam logic [7:0] c_gear_46 = 8'h46;
    localparam logic [7:0] c_gear_45 = 8'h45;
    localparam logic [7:0] c_gear_44 = 8'h44;
    localparam logic [7:0] c_gear_43 = 8'h43;
    localparam logic [7:0] c_gear_42 = 8'h42;
    localparam logic [7:0] c_gear_41 = 8'h41;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_GAP   = 2'd2,
        S_FLUSH = 2'd3
    } sched_state_e;

    // Shared with the write side; a zero length marks an unsupported gear.
    function automatic logic [15:0] gear_frame_len(input logic [7:0] gear);
        logic [15:0] len;
        len = 16'd0;
        case (gear)
            c_gear_52:                       len = 16'd48;
            c_gear_51:                       len = 16'd20;
            c_gear_4f, c_gear_4e:            len = 16'd40;
            c_gear_4d, c_gear_4c:            len = 16'd80;
            c_gear_4b, c_gear_4a:            len = 16'd160;
            c_gear_49:                       len = 16'd320;
            c_gear_48, c_gear_47, c_gear_46,
            c_gear_45, c_gear_44:            len = 16'd160;
            c_gear_43:                       len = 16'd320;
            c_gear_42, c_gear_41:            len = 16'd480;
            default:                         len = 16'd0;
        endcase
        return len;
    endfunction

endpackage
`default_nettype wire

// File: rtl/down_frame_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : down_frame_sched_if
// Description : FIFO read port and downstream byte stream of the scheduler.
// Revision    : 1.0
// ============================================================================
interface down_frame_sched_if;

    logic       fifo_empty;
    logic [7:0] fifo_dout;
    logic       fifo_rd_en;
    logic       out_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_sof;
    logic       out_eof;

    modport master (
        input  fifo_empty,
        input  fifo_dout,
        input  out_ready,
        output fifo_rd_en,
        output out_valid,
        output out_data,
        output out_sof,
        output out_eof
    );

    modport slave (
        output fifo_empty,
        output fifo_dout,
        output out_ready,
        input  fifo_rd_en,
        input  out_valid,
        input  out_data,
        input  out_sof,
        input  out_eof
    );

endinterface
`default_nettype wire

// File: rtl/down_frame_sched_gear_len.sv
`default_nettype none
// ============================================================================
// Module      : down_gear_len
// Description : Registered decode of the active gear into a frame length.
// Revision    : 1.0
// ============================================================================
module down_gear_len
    import down_frame_sched_pkg::*;
(
    input  logic        clk163m84,
    input  logic        rst_n,
    input  logic [7:0]  gear_i,
    output logic [15:0] frame_len_o
);

    logic [15:0] frame_len_q;

    always_ff @(posedge clk163m84 or negedge rst_n) begin
        if (!rst_n) begin
            frame_len_q <= 16'd0;
        end else begin
            frame_len_q <= gear_frame_len(gear_i);
        end
    end

    assign frame_len_o = frame_len_q;

endmodule
`default_nettype wire

// File: rtl/down_frame_sched.sv
`default_nettype none
// ============================================================================
// Module      : down_frame_sched
// Description : Downlink FIFO read scheduler; drains one gear-sized frame per
//               pending frame onto a SOF/EOF byte stream, flushes on gear change.
// Revision    : 1.0
// ============================================================================
module down_frame_sched
    import down_frame_sched_pkg::*;
#(
    parameter int FRAME_CNT_W  = 4,
    parameter int GAP_CYCLES   = 8,
    parameter int FLUSH_CYCLES = 16
) (
    input  logic                   clk163m84,
    input  logic                   rst_n,
    input  logic [7:0]             gear_r,
    input  logic [7:0]             gear_rr,
    input  logic                   frame_done,
    down_frame_sched_if.master     bus,
    output logic [FRAME_CNT_W-1:0] pend_cnt,
    output logic                   ovf_err,
    output logic                   busy
);

    localparam logic [FRAME_CNT_W-1:0] c_PEND_MAX   = '1;
    localparam logic [7:0]             c_GAP_LAST   = 8'(GAP_CYCLES - 1);
    localparam logic [7:0]             c_FLUSH_LAST = 8'(FLUSH_CYCLES - 1);

    sched_state_e           state_q, state_d;
    logic [15:0]            frame_len;
    logic [FRAME_CNT_W-1:0] pend_cnt_q, pend_cnt_d;
    logic                   ovf_err_q, ovf_err_d;
    logic [15:0]            remaining_q, remaining_d;
    logic                   rd_inflight_q, rd_inflight_d;
    logic                   first_q, first_d;
    logic                   out_valid_q, out_valid_d;
    logic [7:0]             out_data_q, out_data_d;
    logic                   out_sof_q, out_sof_d;
    logic                   out_eof_q, out_eof_d;
    logic [7:0]             cnt_q, cnt_d;

    logic w_mismatch;
    logic w_flush;
    logic w_start;
    logic w_accept;
    logic w_eof_acc;
    logic w_rd_en;

    down_gear_len u_gear_len (
        .clk163m84   (clk163m84),
        .rst_n       (rst_n),
        .gear_i      (gear_rr),
        .frame_len_o (frame_len)
    );

    assign w_mismatch = (gear_r != gear_rr);
    assign w_flush    = w_mismatch || (state_q == S_FLUSH);
    assign w_start    = (state_q == S_IDLE) && (pend_cnt_q != '0) &&
                        (frame_len != 16'd0) && !w_mismatch;
    assign w_accept   = out_valid_q && bus.out_ready;
    assign w_eof_acc  = w_accept && out_eof_q;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk163m84 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        if (w_mismatch) begin
            state_d = S_FLUSH;
        end else begin
            case (state_q)
                S_IDLE:  if (w_start)              state_d = S_READ;
                S_READ:  if (w_eof_acc)            state_d = S_GAP;
                S_GAP:   if (cnt_q == c_GAP_LAST)   state_d = S_IDLE;
                S_FLUSH: if (cnt_q == c_FLUSH_LAST) state_d = S_IDLE;
                default:                           state_d = S_IDLE;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    // A read is only issued when the output register is free or draining, so
    // the captured byte never collides with an unaccepted one.
    always_comb begin
        w_rd_en = 1'b0;
        busy    = (state_q != S_IDLE);
        if (state_q == S_READ) begin
            w_rd_en = !w_mismatch && (remaining_q != 16'd0) && !bus.fifo_empty &&
                      !rd_inflight_q && (!out_valid_q || bus.out_ready);
        end
    end

    // ---------------- datapath next state ----------------
    always_comb begin
        pend_cnt_d    = pend_cnt_q;
        ovf_err_d     = ovf_err_q;
        remaining_d   = remaining_q;
        rd_inflight_d = rd_inflight_q;
        first_d       = first_q;
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        out_sof_d     = out_sof_q;
        out_eof_d     = out_eof_q;
        cnt_d         = cnt_q;

        // Counter restarts on every mismatch cycle so the hold-off runs from the last one.
        if (w_mismatch || (state_q == S_READ && w_eof_acc)) begin
            cnt_d = 8'd0;
        end else if (state_q == S_GAP || state_q == S_FLUSH) begin
            cnt_d = cnt_q + 8'd1;
        end

        if (w_flush) begin
            pend_cnt_d    = '0;
            remaining_d   = 16'd0;
            rd_inflight_d = 1'b0;
            first_d       = 1'b0;
            out_valid_d   = 1'b0;
            out_sof_d     = 1'b0;
            out_eof_d     = 1'b0;
        end else begin
            rd_inflight_d = w_rd_en;

            if (w_start) begin
                remaining_d = frame_len;
                first_d     = 1'b1;
            end

            if (w_accept) begin
                out_valid_d = 1'b0;
                out_sof_d   = 1'b0;
                out_eof_d   = 1'b0;
            end

            if (rd_inflight_q) begin
                out_valid_d = 1'b1;
                out_data_d  = bus.fifo_dout;
                out_sof_d   = first_q;
                out_eof_d   = (remaining_q == 16'd1);
                remaining_d = remaining_q - 16'd1;
                first_d     = 1'b0;
            end

            case ({frame_done, w_start})
                2'b10: begin
                    if (pend_cnt_q == c_PEND_MAX) begin
                        ovf_err_d = 1'b1;
                    end else begin
                        pend_cnt_d = pend_cnt_q + 1'b1;
                    end
                end
                2'b01:   pend_cnt_d = pend_cnt_q - 1'b1;
                default: pend_cnt_d = pend_cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk163m84 or negedge rst_n) begin
        if (!rst_n) begin
            pend_cnt_q    <= '0;
            ovf_err_q     <= 1'b0;
            remaining_q   <= 16'd0;
            rd_inflight_q <= 1'b0;
            first_q       <= 1'b0;
            out_valid_q   <= 1'b0;
            out_data_q    <= 8'd0;
            out_sof_q     <= 1'b0;
            out_eof_q     <= 1'b0;
            cnt_q         <= 8'd0;
        end else begin
            pend_cnt_q    <= pend_cnt_d;
            ovf_err_q     <= ovf_err_d;
            remaining_q   <= remaining_d;
            rd_inflight_q <= rd_inflight_d;
            first_q       <= first_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_sof_q     <= out_sof_d;
            out_eof_q     <= out_eof_d;
            cnt_q         <= cnt_d;
        end
    end

    assign bus.fifo_rd_en = w_rd_en;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_sof    = out_sof_q;
    assign bus.out_eof    = out_eof_q;
    assign pend_cnt       = pend_cnt_q;
    assign ovf_err        = ovf_err_q;

endmodule
`default_nettype wire

// File: tb/tb_down_frame_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_down_frame_sched
// Description : Directed self-checking bench for down_frame_sched.
// Revision    : 1.0
// ============================================================================
module tb_down_frame_sched;

    logic       clk;
    logic       rst_n;
    logic [7:0] gear_r;
    logic [7:0] gear_rr;
    logic       frame_done;
    logic [3:0] pend_cnt;
    logic       ovf_err;
    logic       busy;

    down_frame_sched_if bus ();

    down_frame_sched #(
        .FRAME_CNT_W  (4),
        .GAP_CYCLES   (8),
        .FLUSH_CYCLES (16)
    ) dut (
        .clk163m84  (clk),
        .rst_n      (rst_n),
        .gear_r     (gear_r),
        .gear_rr    (gear_rr),
        .frame_done (frame_done),
        .bus        (bus),
        .pend_cnt   (pend_cnt),
        .ovf_err    (ovf_err),
        .busy       (busy)
    );

    // ---------------- FIFO model and downstream sink ----------------
    logic [7:0] mem [0:2047];
    int         wptr;
    int         rptr;
    logic [7:0] dout_q;
    logic       fifo_clr;
    logic       force_empty;
    logic       ready_lvl;
    logic       toggle_en;
    logic       tgl_q;
    int         cyc;

    assign bus.fifo_empty = (rptr == wptr) || force_empty;
    assign bus.fifo_dout  = dout_q;
    assign bus.out_ready  = toggle_en ? tgl_q : ready_lvl;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        tgl_q <= ~tgl_q;
        if (fifo_clr) begin
            rptr <= wptr;
        end else if (bus.fifo_rd_en && rptr != wptr) begin
            dout_q <= mem[rptr];
            rptr   <= rptr + 1;
        end
    end

    logic [7:0] rx_data [0:4095];
    logic       rx_sof  [0:4095];
    logic       rx_eof  [0:4095];
    int         rx_n;
    int         sof_cyc [0:15];
    int         eof_cyc [0:15];
    int         n_sof;
    int         n_eof;
    int         rd_total;
    int         stall_err;
    logic       prev_stall;
    logic [7:0] prev_data;

    initial begin
        cyc = 0; rptr = 0; dout_q = 8'd0; tgl_q = 1'b0;
        rx_n = 0; n_sof = 0; n_eof = 0; rd_total = 0; stall_err = 0;
        prev_stall = 1'b0; prev_data = 8'd0;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.fifo_rd_en) rd_total <= rd_total + 1;
            if (prev_stall && (!bus.out_valid || bus.out_data != prev_data))
                stall_err <= stall_err + 1;
            prev_stall <= bus.out_valid && !bus.out_ready;
            prev_data  <= bus.out_data;
            if (bus.out_valid && bus.out_ready) begin
                rx_data[rx_n] <= bus.out_data;
                rx_sof[rx_n]  <= bus.out_sof;
                rx_eof[rx_n]  <= bus.out_eof;
                rx_n          <= rx_n + 1;
                if (bus.out_sof) begin
                    sof_cyc[n_sof] <= cyc;
                    n_sof          <= n_sof + 1;
                end
                if (bus.out_eof) begin
                    eof_cyc[n_eof] <= cyc;
                    n_eof          <= n_eof + 1;
                end
            end
        end
    end

    // ---------------- checking helpers ----------------
    int n_assert = 0;
    int n_fail   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_done();
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
    endtask

    task automatic preload(input int n, input logic [7:0] first);
        for (int i = 0; i < n; i++) begin
            mem[wptr] = first + 8'(i);
            wptr++;
        end
    endtask

    task automatic set_gear(input logic [7:0] g);
        gear_r = g;
        tick();
        gear_rr  = g;
        fifo_clr = 1'b1;
        tick();
        fifo_clr = 1'b0;
        repeat (20) tick();
    endtask

    task automatic wait_eof(input string tag, input int target, input int bound);
        int k = 0;
        while (n_eof < target && k < bound) begin
            tick();
            k++;
        end
        check(tag, 32'(n_eof >= target), 32'd1);
    endtask

    task automatic wait_rx(input string tag, input int target, input int bound);
        int k = 0;
        while (rx_n < target && k < bound) begin
            tick();
            k++;
        end
        check(tag, 32'(rx_n >= target), 32'd1);
    endtask

    task automatic check_frame(input string tag, input int base, input int len, input logic [7:0] first);
        int         bad = 0;
        logic [7:0] e;
        for (int i = 0; i < len; i++) begin
            e = first + 8'(i);
            if (rx_data[base+i] !== e || rx_sof[base+i] !== (i == 0) ||
                rx_eof[base+i] !== (i == len - 1))
                bad++;
        end
        check({tag, "_bytes"}, 32'(bad), 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int base;
        int s0;
        int e0;
        int t_low;
        int rd0;

        rst_n = 1'b0; gear_r = 8'h51; gear_rr = 8'h51; frame_done = 1'b0;
        ready_lvl = 1'b1; toggle_en = 1'b0; force_empty = 1'b0; fifo_clr = 1'b0;
        wptr = 0;
        repeat (3) tick();
        check("rst_rd_en",  32'(bus.fifo_rd_en), 32'd0);
        check("rst_valid",  32'(bus.out_valid),  32'd0);
        check("rst_sof",    32'(bus.out_sof),    32'd0);
        check("rst_eof",    32'(bus.out_eof),    32'd0);
        check("rst_data",   32'(bus.out_data),   32'd0);
        check("rst_pend",   32'(pend_cnt),       32'd0);
        check("rst_ovf",    32'(ovf_err),        32'd0);
        check("rst_busy",   32'(busy),           32'd0);
        rst_n = 1'b1;
        repeat (3) tick();

        // Gear 0x51: single 20-byte frame, latency and gap
        preload(20, 8'h10);
        base = rx_n; e0 = n_eof;
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        check("t1_pend_t1",  32'(pend_cnt), 32'd1);
        check("t1_busy_t1",  32'(busy),     32'd0);
        tick();
        check("t1_rd_en_t2", 32'(bus.fifo_rd_en), 32'd1);
        check("t1_pend_t2",  32'(pend_cnt),       32'd0);
        wait_eof("t1_eof_wait", e0 + 1, 200);
        check("t1_cnt", 32'(rx_n - base), 32'd20);
        check_frame("t1", base, 20, 8'h10);
        t_low = 0;
        while (busy && t_low < 50) begin
            tick();
            t_low++;
        end
        check("t1_gap_len", 32'(cyc - eof_cyc[e0]), 32'd9);
        check("t1_ovf", 32'(ovf_err), 32'd0);

        // Gear 0x52: 48 bytes with out_ready toggling
        set_gear(8'h52);
        check("t2_idle_after_flush", 32'(busy), 32'd0);
        preload(48, 8'h40);
        base = rx_n; e0 = n_eof;
        toggle_en = 1'b1;
        pulse_done();
        wait_eof("t2_eof_wait", e0 + 1, 500);
        toggle_en = 1'b0;
        check("t2_cnt", 32'(rx_n - base), 32'd48);
        check_frame("t2", base, 48, 8'h40);
        check("t2_stall_hold", 32'(stall_err), 32'd0);

        // Gear 0x4D: back-to-back frames, pending counter, inter-frame gaps
        set_gear(8'h4D);
        preload(320, 8'h00);
        base = rx_n; s0 = n_sof; e0 = n_eof;
        frame_done = 1'b1;
        tick();
        check("t3_pend_a", 32'(pend_cnt), 32'd1);
        tick();
        check("t3_pend_b", 32'(pend_cnt), 32'd1);
        tick();
        frame_done = 1'b0;
        check("t3_pend_c", 32'(pend_cnt), 32'd2);
        wait_rx("t3_rx_wait", base + 5, 100);
        pulse_done();
        check("t3_pend_3", 32'(pend_cnt), 32'd3);
        wait_eof("t3_eof2_wait", e0 + 2, 1000);
        check("t3_pend_after_start", 32'(pend_cnt), 32'd2);
        wait_eof("t3_eof4_wait", e0 + 4, 1000);
        check("t3_cnt", 32'(rx_n - base), 32'd320);
        for (int k = 0; k < 4; k++)
            check_frame($sformatf("t3_f%0d", k), base + 80 * k, 80, 8'(80 * k));
        for (int k = 0; k < 3; k++)
            check($sformatf("t3_gap%0d", k),
                  32'((sof_cyc[s0+k+1] - eof_cyc[e0+k] - 1) >= 8), 32'd1);
        check("t3_pend_end", 32'(pend_cnt), 32'd0);

        // Gear 0x49 -> 0x42 mid-frame: abort, flush, then a 480-byte frame
        set_gear(8'h49);
        preload(320, 8'hA0);
        base = rx_n; e0 = n_eof;
        pulse_done();
        wait_rx("t4_rx100_wait", base + 100, 400);
        gear_r = 8'h42;
        tick();
        check("t4_valid_drop", 32'(bus.out_valid), 32'd0);
        check("t4_pend_clr",   32'(pend_cnt),      32'd0);
        gear_rr  = 8'h42;
        fifo_clr = 1'b1;
        tick();
        fifo_clr   = 1'b0;
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        repeat (13) tick();
        check("t4_flush_busy",   32'(busy),     32'd1);
        check("t4_flush_ignore", 32'(pend_cnt), 32'd0);
        tick();
        check("t4_flush_done", 32'(busy), 32'd0);
        check("t4_no_eof",     32'(n_eof), 32'(e0));
        preload(480, 8'h33);
        base = rx_n;
        pulse_done();
        wait_eof("t4_eof_wait", e0 + 1, 2000);
        check("t4_cnt", 32'(rx_n - base), 32'd480);
        check_frame("t4", base, 480, 8'h33);

        // FIFO empty mid-frame for 50 cycles
        set_gear(8'h51);
        preload(20, 8'hC0);
        base = rx_n; e0 = n_eof;
        pulse_done();
        wait_rx("t5_rx8_wait", base + 8, 100);
        force_empty = 1'b1;
        rd0 = rd_total;
        repeat (50) tick();
        check("t5_no_rd", 32'(rd_total - rd0), 32'd0);
        check("t5_busy",  32'(busy), 32'd1);
        force_empty = 1'b0;
        wait_eof("t5_eof_wait", e0 + 1, 200);
        check("t5_cnt", 32'(rx_n - base), 32'd20);
        check_frame("t5", base, 20, 8'hC0);

        // Invalid gear: pending counter saturation and overflow flag
        set_gear(8'h00);
        rd0 = rd_total;
        frame_done = 1'b1;
        repeat (15) tick();
        check("t6_pend_15", 32'(pend_cnt), 32'd15);
        check("t6_ovf_pre", 32'(ovf_err),  32'd0);
        tick();
        frame_done = 1'b0;
        check("t6_pend_sat", 32'(pend_cnt), 32'd15);
        check("t6_ovf_set",  32'(ovf_err),  32'd1);
        repeat (5) tick();
        check("t6_no_rd",   32'(rd_total - rd0), 32'd0);
        check("t6_idle",    32'(busy),    32'd0);
        check("t6_ovf_sticky", 32'(ovf_err), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
